rc_dec: RTL and testbench
=========================

Name: rc_dec

Overview:
- Receive-side checker/decoder for the 4-bit one-hot ring-counter output bus.
- Samples the ring pattern each valid cycle and converts it to a binary index.
- Locks onto a correctly rotating sequence, then flags sequence breaks, counts errors and counts full rotations.
- Sits downstream of the ring counter, feeding status and debug logic.

Parameters:
- WIDTH, 4, ring width (number of one-hot bits); must be ≥ 2.
- IDX_W, 2, index width; equals clog2(WIDTH).
- LOCK_CNT, 3, number of consecutive correct patterns needed to declare lock; must be ≥ 1.
- CNT_W, 8, width of the error counter and the rotation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  ring pattern under test.
- in_valid  input  1  sample qualifier; when low, the block holds all state.
- idx  output  IDX_W  registered binary index of the last valid one-hot sample.
- onehot  output  1  registered; last valid sample had exactly one bit set.
- locked  output  1  high while the FSM is in LOCKED.
- err  output  1  one-cycle pulse on a sequence break while locked.
- err_cnt  output  CNT_W  saturating count of err pulses.
- wrap  output  1  one-cycle pulse on each completed rotation while locked.
- rot_cnt  output  CNT_W  count of wrap pulses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, any time including mid-lock):
  - idx=0, onehot=0, locked=0, err=0, err_cnt=0, wrap=0, rot_cnt=0.
  - Internal prev=0, match=0, state=SEARCH.
- Rotation direction: left rotate. Expected next pattern is rotl(prev,1), e.g. 0001→0010→0100→1000→0001.
- One-hot test: exactly one bit set. 0000 and any multi-bit pattern are invalid.
- Latency: all outputs are registered and reflect the sample from the previous valid cycle (1-cycle latency).
- When in_valid=0: state, prev, match, idx, onehot and both counters hold; err=0 and wrap=0 that cycle.
- idx and onehot update on every valid cycle. If the sample is not one-hot, idx holds its old value.
- FSM states: SEARCH, LOCKING, LOCKED. In every state, a valid one-hot sample loads prev=in.
- SEARCH:
  - One-hot sample → match=1; go to LOCKING, or straight to LOCKED if LOCK_CNT=1.
  - Non-one-hot sample → stay in SEARCH.
- LOCKING:
  - in==rotl(prev) → match++; on reaching LOCK_CNT, go to LOCKED.
  - Other one-hot sample → match=1, stay in LOCKING.
  - Non-one-hot sample → go to SEARCH, match=0.
  - err is never asserted in SEARCH or LOCKING.
- LOCKED:
  - in==rotl(prev) → stay locked.
  - If additionally prev[WIDTH-1]=1 and in[0]=1 → wrap=1 and rot_cnt++ (modulo).
  - Mismatch → err=1 and err_cnt++, saturating at all-ones (no wrap). locked drops the next cycle.
  - After a mismatch with a one-hot sample: go to LOCKING with match=1. With a non-one-hot sample: go to SEARCH.
- Simultaneous events: a wrap and a mismatch cannot coincide, since wrap requires a match. A reset during an err pulse clears err immediately.

Optional Feature:
- Macro: RC_DEC_BIDIR_EN.
- Defined:
  - Adds output port dir (1 bit; 0=left, 1=right; reset value 0).
  - In LOCKING, the first correct step after match=1 learns the direction:
    - in==rotl(prev) sets dir=0.
    - in==rotr(prev) sets dir=1.
  - Subsequent checks and the LOCKED state use the learned direction.
  - For dir=1, wrap fires on prev[0]=1 and in[WIDTH-1]=1.
- Not defined:
  - No dir port; left rotation only.
  - A right-rotating sequence never locks; each step restarts match at 1.

Decomposition:
- Shared package rc_pkg:
  - State encoding (SEARCH=2'd0, LOCKING=2'd1, LOCKED=2'd2).
  - Default WIDTH, IDX_W and CNT_W constants.
  - rotl/rotr functions.
- One natural sub-module: rc_onehot2bin. It is combinational: WIDTH-bit input → IDX_W index plus a valid flag (exactly-one-set). It is reusable by other ring consumers.
- FSM and counters stay in rc_dec.

Test Plan:
- Reset and lock: hold rst=1 for 50 ns, release, then feed 0001,0010,0100,1000 with in_valid=1 and a 20 ns clock period → locked rises on the cycle after the 3rd valid sample; idx follows 0,1,2,3 with 1-cycle latency; err=0.
- Wrap counting: while locked, feed 3 full rotations → exactly 3 wrap pulses, each on the 1000→0001 step; rot_cnt=3.
- Sequence break: while locked at prev=0010, feed 1000 → err pulses 1 cycle, err_cnt=1, locked=0, state LOCKING. Then feed 0001,0010 → relocks.
- Invalid patterns: while locked, feed 0000, then 0110 → err on 0000, state SEARCH; idx holds 1 (the index of the last one-hot sample, 0010); onehot=0. err_cnt saturation: force 300 breaks with CNT_W=8 → err_cnt stops at 255.
- Stall: while locked, drop in_valid for 5 cycles with in=garbage → no err, no wrap, idx, locked and counters unchanged; the sequence resumes correctly afterward.
- Async reset mid-lock: assert rst between clock edges while locked → all outputs 0 immediately, without waiting for a clock edge. With RC_DEC_BIDIR_EN defined, feed 1000,0100,0010,0001 → locked=1, dir=1.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared types and helpers for ring-counter consumers: FSM state encoding,
// default geometry and width-generic rotate functions.
package rc_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } rc_state_e;

    localparam int unsigned RC_WIDTH    = 4;
    localparam int unsigned RC_IDX_W    = 2;
    localparam int unsigned RC_CNT_W    = 8;
    localparam int unsigned RC_LOCK_CNT = 3;

    // Rotates operate on a zero-extended container so one function serves any ring width.
    localparam int unsigned RC_MAX_W = 32;

    function automatic logic [RC_MAX_W-1:0] rc_mask(input int unsigned w);
        logic [RC_MAX_W-1:0] one;
        one = {{(RC_MAX_W-1){1'b0}}, 1'b1};
        return (w >= RC_MAX_W) ? {RC_MAX_W{1'b1}} : ((one << w) - one);
    endfunction

    function automatic logic [RC_MAX_W-1:0] rotl(input logic [RC_MAX_W-1:0] v,
                                                 input int unsigned         w);
        return ((v << 1) | (v >> (w - 1))) & rc_mask(w);
    endfunction

    function automatic logic [RC_MAX_W-1:0] rotr(input logic [RC_MAX_W-1:0] v,
                                                 input int unsigned         w);
        return ((v >> 1) | (v << (w - 1))) & rc_mask(w);
    endfunction

endpackage

// File: rtl/rc_onehot2bin.sv
// Combinational one-hot to binary encoder with an exactly-one-bit-set flag.
// The index output is meaningful only when valid_o is high.
module rc_onehot2bin
    import rc_pkg::*;
#(
    parameter int unsigned WIDTH = RC_WIDTH,
    parameter int unsigned IDX_W = RC_IDX_W
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] minus_one_s;

    assign minus_one_s = vec_i - WIDTH'(1);
    // Clearing the lowest set bit leaves zero only for a single-bit pattern.
    assign valid_o = (vec_i != {WIDTH{1'b0}}) && ((vec_i & minus_one_s) == {WIDTH{1'b0}});

    // OR-reduce the positions of set bits; exact for one-hot input.
    always_comb begin
        idx_o = {IDX_W{1'b0}};
        for (int i = 0; i < int'(WIDTH); i++) begin
            idx_o = idx_o | (vec_i[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

endmodule

// File: rtl/rc_dec.sv
// Ring-counter receive checker: decodes the one-hot bus, locks onto a rotating
// sequence, flags breaks and counts rotations. RC_DEC_BIDIR_EN adds direction learning.
module rc_dec
    import rc_pkg::*;
#(
    parameter int unsigned WIDTH    = RC_WIDTH,
    parameter int unsigned IDX_W    = RC_IDX_W,
    parameter int unsigned LOCK_CNT = RC_LOCK_CNT,
    parameter int unsigned CNT_W    = RC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [IDX_W-1:0] idx,
    output logic             onehot,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             wrap,
    output logic [CNT_W-1:0] rot_cnt
`ifdef RC_DEC_BIDIR_EN
    ,
    output logic             dir
`endif
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 2);

    rc_state_e        state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [MW-1:0]    match_q, match_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             onehot_q, onehot_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;

    logic [IDX_W-1:0] bin_s;
    logic             oh_s;
    logic [WIDTH-1:0] left_s;
    logic [WIDTH-1:0] exp_s;
    logic             step_ok_s;
    logic             adv_s;
    logic             wrap_hit_s;

    rc_onehot2bin #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec_i   (in),
        .idx_o   (bin_s),
        .valid_o (oh_s)
    );

    assign left_s = WIDTH'(rotl(RC_MAX_W'(prev_q), WIDTH));

`ifdef RC_DEC_BIDIR_EN
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] right_s;
    logic             is_left_s;
    logic             is_right_s;

    assign right_s    = WIDTH'(rotr(RC_MAX_W'(prev_q), WIDTH));
    assign is_left_s  = (in == left_s);
    assign is_right_s = (in == right_s);
    assign exp_s      = dir_q ? right_s : left_s;
    assign wrap_hit_s = dir_q ? (prev_q[0] & in[WIDTH-1]) : (prev_q[WIDTH-1] & in[0]);
    // The first step after a fresh match accepts either direction and teaches it.
    assign adv_s      = (match_q == MW'(1)) ? (is_left_s | is_right_s) : step_ok_s;
    assign dir        = dir_q;
`else
    assign exp_s      = left_s;
    assign wrap_hit_s = prev_q[WIDTH-1] & in[0];
    assign adv_s      = step_ok_s;
`endif

    assign step_ok_s = oh_s && (in == exp_s);

    // Next-state decode for the lock FSM, decoded index and event counters.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        match_d   = match_q;
        idx_d     = idx_q;
        onehot_d  = onehot_q;
        err_d     = 1'b0;
        wrap_d    = 1'b0;
        err_cnt_d = err_cnt_q;
        rot_cnt_d = rot_cnt_q;
`ifdef RC_DEC_BIDIR_EN
        dir_d     = dir_q;
`endif
        if (in_valid) begin
            onehot_d = oh_s;
            if (oh_s) begin
                idx_d  = bin_s;
                prev_d = in;
            end else begin
                idx_d  = idx_q;
                prev_d = prev_q;
            end
            case (state_q)
                SEARCH: begin
                    if (oh_s) begin
                        match_d = MW'(1);
                        state_d = (LOCK_CNT == 1) ? LOCKED : LOCKING;
                    end else begin
                        match_d = {MW{1'b0}};
                        state_d = SEARCH;
                    end
                end
                LOCKING: begin
                    if (!oh_s) begin
                        match_d = {MW{1'b0}};
                        state_d = SEARCH;
                    end else if (adv_s) begin
`ifdef RC_DEC_BIDIR_EN
                        if (match_q == MW'(1)) begin
                            dir_d = ~is_left_s;
                        end else begin
                            dir_d = dir_q;
                        end
`endif
                        if (match_q >= MW'(LOCK_CNT - 1)) begin
                            match_d = MW'(LOCK_CNT);
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + MW'(1);
                            state_d = LOCKING;
                        end
                    end else begin
                        match_d = MW'(1);
                        state_d = LOCKING;
                    end
                end
                LOCKED: begin
                    if (step_ok_s) begin
                        state_d = LOCKED;
                        if (wrap_hit_s) begin
                            wrap_d    = 1'b1;
                            rot_cnt_d = rot_cnt_q + CNT_W'(1);
                        end else begin
                            wrap_d    = 1'b0;
                            rot_cnt_d = rot_cnt_q;
                        end
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q
                                                                 : err_cnt_q + CNT_W'(1);
                        if (oh_s) begin
                            match_d = MW'(1);
                            state_d = LOCKING;
                        end else begin
                            match_d = {MW{1'b0}};
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    match_d = {MW{1'b0}};
                    state_d = SEARCH;
                end
            endcase
        end else begin
            onehot_d = onehot_q;
        end
        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs; async reset returns everything to SEARCH/zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            prev_q    <= {WIDTH{1'b0}};
            match_q   <= {MW{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            onehot_q  <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            err_cnt_q <= {CNT_W{1'b0}};
            rot_cnt_q <= {CNT_W{1'b0}};
`ifdef RC_DEC_BIDIR_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            match_q   <= match_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            err_cnt_q <= err_cnt_d;
            rot_cnt_q <= rot_cnt_d;
`ifdef RC_DEC_BIDIR_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign idx     = idx_q;
    assign onehot  = onehot_q;
    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign wrap    = wrap_q;
    assign rot_cnt = rot_cnt_q;

endmodule

// File: tb/tb_rc_dec.sv
// Directed bench for rc_dec: vector table for lock/wrap/break/stall behaviour plus
// hand sequences for async reset, err_cnt saturation and direction (RC_DEC_BIDIR_EN).
module tb_rc_dec;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       in_valid;
    logic [1:0] idx;
    logic       onehot;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic       wrap;
    logic [7:0] rot_cnt;
`ifdef RC_DEC_BIDIR_EN
    logic       dir;
`endif

    int tests_run;
    int tests_failed;

    rc_dec #(
        .WIDTH    (4),
        .IDX_W    (2),
        .LOCK_CNT (3),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (din),
        .in_valid (in_valid),
        .idx      (idx),
        .onehot   (onehot),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .wrap     (wrap),
        .rot_cnt  (rot_cnt)
`ifdef RC_DEC_BIDIR_EN
        ,
        .dir      (dir)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] in;
        logic [1:0] idx;
        logic       oh;
        logic       lk;
        logic       er;
        logic       wr;
        logic [7:0] ec;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic v, input logic [3:0] in, input logic [1:0] ix,
                                input logic oh, input logic lk, input logic er,
                                input logic wr, input logic [7:0] ec, input logic [7:0] rc);
        vec_t r;
        r.v = v; r.in = in; r.idx = ix; r.oh = oh; r.lk = lk;
        r.er = er; r.wr = wr; r.ec = ec; r.rc = rc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] in);
        in_valid = v;
        din      = in;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " idx"},     32'(idx),     32'd0);
        chk({tag, " onehot"},  32'(onehot),  32'd0);
        chk({tag, " locked"},  32'(locked),  32'd0);
        chk({tag, " err"},     32'(err),     32'd0);
        chk({tag, " wrap"},    32'(wrap),    32'd0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, " rot_cnt"}, 32'(rot_cnt), 32'd0);
`ifdef RC_DEC_BIDIR_EN
        chk({tag, " dir"},     32'(dir),     32'd0);
`endif
    endtask

    initial begin
        logic [4:0] exp_lk;
        logic [4:0] exp_wr;
        logic [3:0] rseq[5];
        logic [1:0] ridx[5];
        int         err_pulses;

        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        din      = 4'b0000;

        //           v     in       idx   oh    lk    err   wrap  ec     rc
        tbl[0]  = mk(1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        tbl[1]  = mk(1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        tbl[2]  = mk(1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        tbl[3]  = mk(1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        tbl[4]  = mk(1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd1);
        tbl[5]  = mk(1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
        tbl[6]  = mk(1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
        tbl[7]  = mk(1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
        tbl[8]  = mk(1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd2);
        tbl[9]  = mk(1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2);
        tbl[10] = mk(1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2);
        tbl[11] = mk(1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2);
        tbl[12] = mk(1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd3);
        tbl[13] = mk(1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd3);
        // break at prev=0010, then relock
        tbl[14] = mk(1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd3);
        tbl[15] = mk(1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd3);
        tbl[16] = mk(1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd3);
        // non-one-hot samples while locked
        tbl[17] = mk(1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd3);
        tbl[18] = mk(1'b1, 4'b0110, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[19] = mk(1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[20] = mk(1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[21] = mk(1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        // stall with garbage on the bus
        tbl[22] = mk(1'b0, 4'b1111, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[23] = mk(1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[24] = mk(1'b0, 4'b0101, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[25] = mk(1'b0, 4'b0001, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[26] = mk(1'b0, 4'b0011, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[27] = mk(1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[28] = mk(1'b0, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
        tbl[29] = mk(1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd4);

        #40;
        chk_all_zero("in_reset");
        #10;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].v, tbl[i].in);
            chk($sformatf("row%0d idx", i),     32'(idx),     32'(tbl[i].idx));
            chk($sformatf("row%0d onehot", i),  32'(onehot),  32'(tbl[i].oh));
            chk($sformatf("row%0d locked", i),  32'(locked),  32'(tbl[i].lk));
            chk($sformatf("row%0d err", i),     32'(err),     32'(tbl[i].er));
            chk($sformatf("row%0d wrap", i),    32'(wrap),    32'(tbl[i].wr));
            chk($sformatf("row%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].ec));
            chk($sformatf("row%0d rot_cnt", i), 32'(rot_cnt), 32'(tbl[i].rc));
        end

        // Break (prev=0001, expected 0010), then reset in the middle of the err pulse.
        drive(1'b1, 4'b1000);
        chk("break err", 32'(err), 32'd1);
        chk("break err_cnt", 32'(err_cnt), 32'd3);
        #4 rst = 1'b1;
        #1 chk_all_zero("rst_during_err");
        @(negedge clk);
        rst = 1'b0;

        // Relock, then async reset between edges while locked.
        drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0010);
        drive(1'b1, 4'b0100);
        chk("relock locked", 32'(locked), 32'd1);
        drive(1'b1, 4'b1000);
        drive(1'b1, 4'b0001);
        chk("pre_rst rot_cnt", 32'(rot_cnt), 32'd1);
        #5 rst = 1'b1;
        #1 chk_all_zero("rst_mid_lock");
        @(negedge clk);
        rst = 1'b0;

        // err_cnt saturation: 300 breaks, each followed by a relock.
        drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0010);
        drive(1'b1, 4'b0100);
        err_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'b0001);
            if (err) err_pulses++;
            drive(1'b1, 4'b0010);
            if (err) err_pulses++;
            drive(1'b1, 4'b0100);
            if (err) err_pulses++;
            if (i == 253) chk("sat err_cnt@254", 32'(err_cnt), 32'd254);
            if (i == 254) chk("sat err_cnt@255", 32'(err_cnt), 32'd255);
        end
        chk("sat err_cnt@300", 32'(err_cnt), 32'd255);
        chk("sat err pulses", 32'(err_pulses), 32'd300);
        chk("sat locked", 32'(locked), 32'd1);

        // Right-rotating sequence from reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rseq[0] = 4'b1000; rseq[1] = 4'b0100; rseq[2] = 4'b0010;
        rseq[3] = 4'b0001; rseq[4] = 4'b1000;
        ridx[0] = 2'd3; ridx[1] = 2'd2; ridx[2] = 2'd1; ridx[3] = 2'd0; ridx[4] = 2'd3;
`ifdef RC_DEC_BIDIR_EN
        exp_lk = 5'b11100;
        exp_wr = 5'b10000;
`else
        exp_lk = 5'b00000;
        exp_wr = 5'b00000;
`endif
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rseq[i]);
            chk($sformatf("rot_r%0d idx", i),    32'(idx),    32'(ridx[i]));
            chk($sformatf("rot_r%0d locked", i), 32'(locked), 32'(exp_lk[i]));
            chk($sformatf("rot_r%0d wrap", i),   32'(wrap),   32'(exp_wr[i]));
            chk($sformatf("rot_r%0d err", i),    32'(err),    32'd0);
        end
`ifdef RC_DEC_BIDIR_EN
        chk("rot_r dir", 32'(dir), 32'd1);
        chk("rot_r rot_cnt", 32'(rot_cnt), 32'd1);
`else
        chk("rot_r rot_cnt", 32'(rot_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
